rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among 8 requesters; the resource is selected through the team's 3-to-8 decoder path.
- Registers a 3-bit winner index, enables it, and drives a one-hot grant equal to a 3-to-8 decode of that index.
- Sequences ownership: grant, hold until release, then advance priority.
- Sits between requesting units and the shared datapath whose enable is gated by the decoded grant.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 to match the 3-to-8 decode.
- IDX_W, 3, width of the grant index.
- MAX_HOLD, 15, maximum cycles a grant may be held; used only when the optional feature is compiled in.
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK  in  1  rising-edge clock; the block's only clock.
- RST  in  1  asynchronous reset, active-high.
- En  in  1  global arbiter enable; low forces no grant.
- Req  in  8  request vector; bit i high = requester i wants the resource.
- Done  in  1  current owner releases the resource this cycle.
- Gnt  out  8  one-hot grant, registered; all zero when no grant.
- GntIdx  out  3  binary index of the current or last owner.
- GntVld  out  1  a grant is active; equals |Gnt.
- Timeout  out  1  one-cycle pulse on forced release; tied 0 when the feature is compiled out.

Behaviour:
- Reset (RST high, async): state=IDLE, Gnt=8'h00, GntIdx=0, GntVld=0, Timeout=0, priority pointer Ptr=0, hold counter=0. RST asserted mid-grant drops Gnt immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE -> GRANT:
  - Condition: En=1 and Req!=0 at a rising edge.
  - Winner: first i with Req[i]=1, searching Ptr, Ptr+1, ..., 7, 0, ..., Ptr-1 (mod 8).
  - At that edge: GntIdx<=winner, Gnt<=1<<winner, GntVld<=1. Latency from sampled request to grant is 1 cycle.
- GRANT hold: Gnt stays stable while En=1, Done=0 and Req[GntIdx]=1. New requests from other requesters do not preempt.
- GRANT -> IDLE (release):
  - Condition: Done=1 or Req[GntIdx]=0 at an edge. Simultaneous Done and request drop count as one release.
  - At that edge: Gnt<=0, GntVld<=0, Ptr<=GntIdx+1 mod 8 (7 wraps to 0). GntIdx holds its value.
- Dead cycle: every release is followed by at least one IDLE cycle with Gnt=0 before the next grant. Back-to-back owners are therefore spaced by one cycle.
- En=0 in GRANT: release at the next edge, but Ptr is unchanged, so the same requester keeps priority when En returns.
- En=0 in IDLE: no grant.
- Done in IDLE: ignored.
- Gnt is never multi-hot. Gnt=0 exactly when GntVld=0.
- Fairness: with all 8 requesting continuously, grants rotate 0, 1, ..., 7, 0 in order.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments every cycle in GRANT.
  - When the counter reaches MAX_HOLD without a release, the block forces a release at that edge: Gnt<=0, Ptr advances as for a normal release, Timeout=1 for exactly one cycle.
  - A normal release on the same edge takes precedence, and Timeout stays 0.
- Undefined: no counter is built, Timeout is constant 0, and a grant is held indefinitely.

Test Plan:
- Reset: RST=1 pulsed with no clock edge -> Gnt=00, GntVld=0, GntIdx=0 immediately; after release, Req=8'h01 -> Gnt=8'h01 one cycle later.
- Rotation: Req=8'hFF held, Done pulsed one cycle after each grant -> GntIdx sequence 0,1,2,...,7,0, with one Gnt=00 cycle between grants.
- Wrap/skip: Ptr=6 (after a grant to requester 5), Req=8'h05 -> grant to 0 (Gnt=8'h01); after release Ptr=1, next grant goes to 2 (Gnt=8'h04).
- Enable: grant active on 3, En dropped -> Gnt=00 next cycle; En raised with Req=8'h18 -> grant returns to 3 (Gnt=8'h08), not 4.
- Request drop: owner 4 deasserts Req[4] with Done=0 -> release; pending Req[5] is granted after the dead cycle (Gnt=8'h20).
- With RR_GRANT_TIMEOUT_EN, MAX_HOLD=15: owner never releases -> forced release 15 cycles after grant, Timeout high 1 cycle, next requester granted.
- Without RR_GRANT_TIMEOUT_EN: same stimulus -> grant held for 100+ cycles, Timeout stays 0.

Source files
------------

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesting units and rr_grant_arbiter.
// Signalling contract: the requester side drives en/req/done and holds
// req[i] high for as long as it wants the resource. The arbiter answers with
// a registered one-hot gnt plus its binary index. A grant persists until the
// owner pulses done or drops its req bit. Neither side ever waits on a
// combinational response from the other.
interface rr_grant_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    // requesting side
    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    // arbiter side
    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_vld, timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// The winner index is registered and decoded 3-to-8 into a one-hot grant.
// A grant is held until the owner releases it. Priority then moves to the
// requester after the owner. Every release is followed by at least one idle
// cycle.
// Optional feature: define RR_GRANT_TIMEOUT_EN to force a release after
// MAX_HOLD cycles of ownership, flagged by a one-cycle timeout pulse.
module rr_grant_arbiter #(
    parameter int NREQ     = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_grant_arbiter_if.slave bus,
    output logic              dbg_state
);

    // Elaboration-time sanity checks on the configuration.
    if (NREQ != (1 << IDX_W)) begin : g_bad_nreq
        $error("NREQ must equal 2**IDX_W for the 3-to-8 decode");
    end
    if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
        $error("CNT_W too narrow to count up to MAX_HOLD");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [NREQ-1:0]    gnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               vld_q;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic               winner_vld;
    logic [IDX_W-1:0]   cand;

    // 3-to-8 decode of the winner index into the one-hot grant.
    function automatic logic [NREQ-1:0] decode_idx(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

    // Circular priority search starting at ptr. Scanning from the farthest
    // offset down lets the nearest requester overwrite the others.
    always_comb begin
        winner     = ptr;
        winner_vld = 1'b0;
        cand       = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (bus.req[cand]) begin
                winner     = cand;
                winner_vld = 1'b1;
            end
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    // Ownership FSM with hold counter. The counter tracks cycles already
    // spent in GRANT, so the edge that would complete MAX_HOLD forces release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && winner_vld) begin
                        state    <= GRANT;
                        idx_q    <= winner;
                        gnt_q    <= decode_idx(winner);
                        vld_q    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!bus.en) begin
                        // Disabled: drop the grant but keep priority on the owner.
                        state <= IDLE;
                        gnt_q <= '0;
                        vld_q <= 1'b0;
                    end else if (bus.done || !bus.req[idx_q]) begin
                        state <= IDLE;
                        gnt_q <= '0;
                        vld_q <= 1'b0;
                        ptr   <= idx_q + IDX_W'(1);
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= IDLE;
                        gnt_q     <= '0;
                        vld_q     <= 1'b0;
                        ptr       <= idx_q + IDX_W'(1);
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.timeout = timeout_q;
`else
    // Ownership FSM. A grant is held until the owner releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en && winner_vld) begin
                        state <= GRANT;
                        idx_q <= winner;
                        gnt_q <= decode_idx(winner);
                        vld_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!bus.en) begin
                        // Disabled: drop the grant but keep priority on the owner.
                        state <= IDLE;
                        gnt_q <= '0;
                        vld_q <= 1'b0;
                    end else if (bus.done || !bus.req[idx_q]) begin
                        state <= IDLE;
                        gnt_q <= '0;
                        vld_q <= 1'b0;
                        ptr   <= idx_q + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign dbg_state   = (state == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: a behavioural ownership model that predicts
// every cycle, plus directed scenarios with hand-computed literal results.
module tb_rr_grant_arbiter;

    localparam int MAX_HOLD = 15;
    localparam int W        = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;

    rr_grant_arbiter_if bus ();

    rr_grant_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 when none), priority start, last owner and age.
    logic [W-1:0] exp_q[$];
    int           m_owner, m_ptr, m_last, m_age, w;
    logic         m_to;
    logic [7:0]   m_gnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_last  = 0;
            m_age   = 0;
            m_to    = 1'b0;
            exp_q.delete();
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                if (bus.en) begin
                    w = -1;
                    for (int k = 0; k < 8; k++)
                        if (w < 0 && bus.req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                    if (w >= 0) begin
                        m_owner = w;
                        m_last  = w;
                        m_age   = 0;
                    end
                end
            end else if (!bus.en) begin
                m_owner = -1;
            end else if (bus.done || !bus.req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_age++;
`ifdef RR_GRANT_TIMEOUT_EN
                if (m_age == MAX_HOLD) begin
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_to    = 1'b1;
                end
`endif
            end
            m_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
            exp_q.push_back({(m_owner >= 0), m_to, (m_owner >= 0), 3'(m_last), m_gnt});
        end
    end

    // scoreboard: one prediction per clock edge, checked on the falling edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_gnt",     {24'h0, bus.gnt},     {24'h0, e[7:0]});
            check("sb_gnt_idx", {29'h0, bus.gnt_idx}, {29'h0, e[10:8]});
            check("sb_gnt_vld", {31'h0, bus.gnt_vld}, {31'h0, e[11]});
            check("sb_timeout", {31'h0, bus.timeout}, {31'h0, e[12]});
            check("sb_state",   {31'h0, dbg_state},   {31'h0, e[13]});
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_vld(input logic lvl, input string name);
        for (int i = 0; i < 50; i++) begin
            if (bus.gnt_vld === lvl) break;
            @(negedge clk);
        end
        check(name, {31'h0, bus.gnt_vld}, {31'h0, lvl});
    endtask

    int held;
    int pulses;
    int hold_len;

    initial begin
        bus.en   = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        tick(2);
        check("rst_gnt",     {24'h0, bus.gnt},     32'h0);
        check("rst_vld",     {31'h0, bus.gnt_vld}, 32'h0);
        check("rst_idx",     {29'h0, bus.gnt_idx}, 32'h0);
        check("rst_timeout", {31'h0, bus.timeout}, 32'h0);
        rst = 1'b0;

        // asynchronous reset in the middle of a grant
        bus.en  = 1'b1;
        bus.req = 8'h08;
        tick(1);
        check("pre_async_gnt", {24'h0, bus.gnt}, 32'h08);
        #1 rst = 1'b1;
        #1;
        check("async_gnt", {24'h0, bus.gnt},     32'h0);
        check("async_vld", {31'h0, bus.gnt_vld}, 32'h0);
        check("async_idx", {29'h0, bus.gnt_idx}, 32'h0);
        #1 rst = 1'b0;
        bus.req = 8'h01;
        tick(1);
        check("post_rst_gnt", {24'h0, bus.gnt}, 32'h01);
        bus.req = 8'h00;
        tick(2);

        // rotation with all requesting
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_vld(1'b1, "rot_wait");
            check("rot_idx", {29'h0, bus.gnt_idx}, 32'(k % 8));
            bus.done = 1'b1;
            tick(1);
            bus.done = 1'b0;
            check("rot_dead", {24'h0, bus.gnt}, 32'h0);
        end
        bus.req = 8'h00;
        tick(2);

        // wrap and skip: pointer at 6, then at 1
        do_reset();
        bus.req = 8'h20;
        wait_vld(1'b1, "wrap_wait5");
        check("wrap_gnt5", {24'h0, bus.gnt}, 32'h20);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        bus.req  = 8'h05;
        wait_vld(1'b1, "wrap_wait0");
        check("wrap_gnt0", {24'h0, bus.gnt}, 32'h01);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        wait_vld(1'b1, "wrap_wait2");
        check("wrap_gnt2", {24'h0, bus.gnt}, 32'h04);
        bus.req = 8'h00;
        tick(2);

        // enable drop keeps priority on the owner
        do_reset();
        bus.req = 8'h08;
        wait_vld(1'b1, "en_wait3");
        check("en_gnt3", {24'h0, bus.gnt}, 32'h08);
        bus.en  = 1'b0;
        bus.req = 8'h18;
        tick(1);
        check("en_off_gnt", {24'h0, bus.gnt}, 32'h0);
        tick(2);
        check("en_off_idle", {24'h0, bus.gnt}, 32'h0);
        bus.en = 1'b1;
        wait_vld(1'b1, "en_wait_back");
        check("en_back_gnt", {24'h0, bus.gnt},     32'h08);
        check("en_back_idx", {29'h0, bus.gnt_idx}, 32'h3);
        bus.req = 8'h00;
        tick(2);

        // owner drops its request without done
        do_reset();
        bus.req = 8'h10;
        wait_vld(1'b1, "drop_wait4");
        check("drop_gnt4", {24'h0, bus.gnt}, 32'h10);
        bus.req = 8'h20;
        tick(1);
        check("drop_dead", {24'h0, bus.gnt}, 32'h0);
        tick(1);
        check("drop_gnt5", {24'h0, bus.gnt}, 32'h20);
        bus.req = 8'h00;
        tick(2);

        // owner never releases
        do_reset();
        bus.req = 8'h06;
        wait_vld(1'b1, "hold_wait");
        check("hold_gnt1", {24'h0, bus.gnt}, 32'h02);
`ifdef RR_GRANT_TIMEOUT_EN
        hold_len = 20;
`else
        hold_len = 120;
`endif
        held   = 0;
        pulses = 0;
        for (int i = 0; i < hold_len; i++) begin
            if (bus.gnt === 8'h02) held++;
            if (bus.timeout === 1'b1) pulses++;
            @(negedge clk);
        end
`ifdef RR_GRANT_TIMEOUT_EN
        check("to_held",   32'(held),   32'd15);
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_next",   {24'h0, bus.gnt}, 32'h04);
`else
        check("hold_held",   32'(held),   32'd120);
        check("hold_pulses", 32'(pulses), 32'd0);
        check("hold_still",  {24'h0, bus.gnt}, 32'h02);
`endif
        bus.req = 8'h00;
        tick(3);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
